// File: rtl/interrupt_ack_decoder_if.sv
// Interrupt request/acknowledge bundle shared by the decoder and whatever
// drives its sources and acknowledges (the master side).
interface interrupt_ack_decoder_if #(
    parameter int unsigned N_IRQ = 4,
    parameter int unsigned ID_W  = 2
);
    logic [N_IRQ-1:0] irq_src;
    logic [N_IRQ-1:0] irq_mask;
    logic [N_IRQ-1:0] pending;
    logic             ack_valid;
    logic [ID_W-1:0]  ack_id;
    logic             ack_ready;
    logic             eoi;
    logic             in_service;
    logic [ID_W-1:0]  active_id;
    logic             ack_err;

    modport master (
        output irq_src, irq_mask, ack_valid, ack_id, eoi,
        input  pending, ack_ready, in_service, active_id, ack_err
    );

    modport slave (
        input  irq_src, irq_mask, ack_valid, ack_id, eoi,
        output pending, ack_ready, in_service, active_id, ack_err
    );
endinterface

// File: rtl/interrupt_ack_decoder.sv
// Edge-captures interrupt sources into a pending register, accepts an id
// acknowledge, and tracks the single in-service interrupt until EOI.
module interrupt_ack_decoder #(
    parameter int unsigned N_IRQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    interrupt_ack_decoder_if.slave  bus
);
    typedef enum logic {IDLE, SERVICE} state_t;

    state_t           state_q;
    logic [N_IRQ-1:0] src_prev_q;
    logic [N_IRQ-1:0] pend_q;
    logic [N_IRQ-1:0] pend_d;
    logic             in_service_q;
    logic [ID_W-1:0]  active_id_q;
    logic             ack_err_q;

    logic [N_IRQ-1:0] pending_w;
    logic [N_IRQ-1:0] edge_w;
    logic [N_IRQ-1:0] clr_w;
    logic             accept_w;

    always_comb begin
        pending_w = pend_q & ~bus.irq_mask;
        edge_w    = bus.irq_src & ~src_prev_q;
        accept_w  = (state_q == IDLE) && bus.ack_valid && pending_w[bus.ack_id];
        clr_w     = '0;
        if (accept_w) begin
            clr_w[bus.ack_id] = 1'b1;
        end
        // A fresh edge on the bit being acknowledged is kept as a new event.
        pend_d    = (pend_q & ~clr_w) | edge_w;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            src_prev_q   <= '0;
            pend_q       <= '0;
            in_service_q <= 1'b0;
            active_id_q  <= '0;
            ack_err_q    <= 1'b0;
        end else begin
            src_prev_q <= bus.irq_src;
            pend_q     <= pend_d;
            ack_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_w) begin
                        state_q      <= SERVICE;
                        in_service_q <= 1'b1;
                        active_id_q  <= bus.ack_id;
                    end else if (bus.ack_valid) begin
                        ack_err_q <= 1'b1;
                    end
                end
                SERVICE: begin
                    // Acknowledges are never queued behind an in-service id.
                    if (bus.ack_valid) begin
                        ack_err_q <= 1'b1;
                    end
                    if (bus.eoi) begin
                        state_q      <= IDLE;
                        in_service_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.pending    = pending_w;
    assign bus.ack_ready  = (state_q == IDLE);
    assign bus.in_service = in_service_q;
    assign bus.active_id  = active_id_q;
    assign bus.ack_err    = ack_err_q;
endmodule
